// File: rtl/uart_pkg.sv
// uart_pkg: state, entry types and parity helper shared by the UART receive path
package uart_pkg;
  localparam int MAX_DATA_BITS = 9;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] d, input logic par_bit, input logic odd);
    return ^d ^ par_bit ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead synchronous FIFO; rd_data always presents the head entry
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  // a pop frees the slot the same cycle, so a push into a full FIFO is accepted alongside it
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_q];
  assign count = count_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo_core.sv
// uart_rx_fifo_core: oversampled UART receiver with per-character error flags,
// sticky overrun/break flags and a show-ahead receive FIFO
module uart_rx_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_in,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_odd,
  input  logic                            cfg_two_stop,
  input  logic                            rx_ready,
  input  logic                            clear_errs,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  output logic                            break_det
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;
  logic [SYNC_STAGES-1:0] sync_q;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic par_q, par_d, stop_q, stop_d, hold_q, hold_d;
  logic pen_q, pen_d, odd_q, odd_d, two_q, two_d;
  logic overrun_q, break_q;
  logic rx_s, mid, last_stop, first_stop, ferr, perr, is_brk;
  logic push, brk_set, ovr_set, pop, full, empty;
  logic [EW-1:0] head;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign mid = cnt_q == CW'(OVERSAMPLE / 2 - 1);
  assign last_stop = bit_q == BW'(two_q);
  assign first_stop = two_q ? stop_q : rx_s;
  assign ferr = ~(first_stop & rx_s);
  assign perr = pen_q & parity_calc(MAX_DATA_BITS'(data_q), par_q, odd_q);
  assign is_brk = ~|data_q & ~(pen_q & par_q) & ~(first_stop | rx_s);
  assign pop = rx_valid & rx_ready;
  assign ovr_set = push & full & ~pop;
  assign rx_valid = ~empty;
  assign {rx_frame_err, rx_parity_err, rx_data} = head;
  assign overrun = overrun_q;
  assign break_det = break_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    data_d = data_q;
    par_d = par_q;
    stop_d = stop_q;
    hold_d = hold_q;
    pen_d = pen_q;
    odd_d = odd_q;
    two_d = two_q;
    push = 1'b0;
    brk_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (mid) begin
        state_d = rx_s ? IDLE : DATA;
        bit_d = '0;
        if (!rx_s) begin
          pen_d = cfg_parity_en;
          odd_d = cfg_parity_odd;
          two_d = cfg_two_stop;
        end
      end
      DATA: if (mid) begin
        data_d = {rx_s, data_q[DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = pen_q ? PARITY : STOP;
          bit_d = '0;
        end
      end
      PARITY: if (mid) begin
        par_d = rx_s;
        state_d = STOP;
      end
      STOP: if (hold_q) begin
        // a break keeps us here until the line is released
        if (rx_s) begin
          state_d = IDLE;
          hold_d = 1'b0;
        end
      end else if (mid) begin
        if (!last_stop) begin
          stop_d = rx_s;
          bit_d = bit_q + 1'b1;
        end else if (is_brk) begin
          brk_set = 1'b1;
          hold_d = 1'b1;
        end else begin
          push = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      stop_q <= 1'b0;
      hold_q <= 1'b0;
      pen_q <= 1'b0;
      odd_q <= 1'b0;
      two_q <= 1'b0;
      overrun_q <= 1'b0;
      break_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(rx_in);
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      data_q <= data_d;
      par_q <= par_d;
      stop_q <= stop_d;
      hold_q <= hold_d;
      pen_q <= pen_d;
      odd_q <= odd_d;
      two_q <= two_d;
      overrun_q <= ovr_set | (overrun_q & ~clear_errs);
      break_q <= brk_set | (break_q & ~clear_errs);
    end
  uart_rx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wr_data({ferr, perr, data_q}),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// tb_uart_rx_fifo_core: scenario tasks driving serial frames against a queue-based receiver model
module tb_uart_rx_fifo_core;
  localparam int OS = 16, DEPTH = 4, SYNC = 2;
  logic clk = 0, rst = 1, rx_in = 1, pen = 0, odd = 0, two = 0, rx_ready = 0, clear_errs = 0;
  logic [7:0] rx_data;
  logic rx_parity_err, rx_frame_err, rx_valid, overrun, break_det;
  logic [2:0] fifo_count;
  logic [6:0] d7_data;
  logic d7_perr, d7_ferr, d7_valid, d7_ovr, d7_brk;
  logic [2:0] d7_count;
  int checks = 0, errors = 0, valid_at;
  logic [9:0] exp_q[$];
  logic exp_ovr = 0, exp_brk = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .cfg_parity_en(pen), .cfg_parity_odd(odd),
    .cfg_two_stop(two), .rx_ready(rx_ready), .clear_errs(clear_errs), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_valid(rx_valid),
    .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det));

  uart_rx_fifo_core #(.DATA_BITS(7), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx_in), .cfg_parity_en(pen), .cfg_parity_odd(odd),
    .cfg_two_stop(two), .rx_ready(rx_ready), .clear_errs(clear_errs), .rx_data(d7_data),
    .rx_parity_err(d7_perr), .rx_frame_err(d7_ferr), .rx_valid(d7_valid),
    .fifo_count(d7_count), .overrun(d7_ovr), .break_det(d7_brk));

  // negedge index (from the start-bit negedge) of the cycle holding the last stop bit's mid-sample
  function automatic int done_idx(input int nb, input logic p_en, input logic two_stop);
    return SYNC + 1 + OS * (nb + int'(p_en) + int'(two_stop) + 1) + OS / 2 - 1;
  endfunction

  task automatic send(input logic [8:0] d, input int nb, input logic p_en, p_odd, two_stop,
                      pbit, s1, s2, input int act_at, input logic act_clr, act_pop);
    logic bits[$];
    int idx;
    logic seen;
    idx = 0;
    seen = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (p_en) bits.push_back(pbit);
    bits.push_back(s1);
    if (two_stop) bits.push_back(s2);
    pen = p_en; odd = p_odd; two = two_stop; valid_at = -1;
    foreach (bits[b]) begin
      rx_in = bits[b];
      repeat (OS) begin
        @(negedge clk);
        idx++;
        if (!seen && rx_valid) begin seen = 1; valid_at = idx; end
        if (idx == 2 * OS) begin pen = 1'($urandom); odd = 1'($urandom); two = 1'($urandom); end
        if (idx == act_at) begin clear_errs = act_clr; rx_ready = act_pop; end
        if (idx == act_at + 1) begin clear_errs = 0; rx_ready = 0; end
      end
    end
    rx_in = 1;
    repeat (2 * OS) @(negedge clk);
  endtask

  task automatic model(input logic [7:0] d, input logic p_en, p_odd, two_stop, pbit, s1, s2,
                       input logic cleared, popped);
    int ones;
    logic perr, ferr, brk;
    ones = $countones(d) + int'(p_en & pbit);
    perr = p_en && ((ones % 2 == 1) != p_odd);
    ferr = !s1 || (two_stop && !s2);
    brk = d == 0 && !(p_en && pbit) && !s1 && (!two_stop || !s2);
    if (cleared) begin exp_ovr = 0; exp_brk = 0; end
    if (popped) void'(exp_q.pop_front());
    if (brk) exp_brk = 1;
    else if (exp_q.size() < DEPTH) exp_q.push_back({ferr, perr, d});
    else exp_ovr = 1;
  endtask

  task automatic xfer(input logic [7:0] d, input logic p_en, p_odd, two_stop, pbit, s1, s2, clr, pop);
    send({1'b0, d}, 8, p_en, p_odd, two_stop, pbit, s1, s2, done_idx(8, p_en, two_stop), clr, pop);
    model(d, p_en, p_odd, two_stop, pbit, s1, s2, clr, pop);
  endtask

  task automatic do_reset();
    rst = 1; rx_in = 1; rx_ready = 0; clear_errs = 0;
    @(negedge clk);
    rst = 0;
    exp_q.delete(); exp_ovr = 0; exp_brk = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drain(input string tag);
    logic [9:0] e;
    checks++;
    if (fifo_count !== 3'(exp_q.size())) begin
      errors++; $display("FAIL %s count: got %0d expected %0d", tag, fifo_count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rx_valid, rx_frame_err, rx_parity_err, rx_data} !== {1'b1, e}) begin
        errors++;
        $display("FAIL %s head: got v=%b f=%b p=%b d=%h expected v=1 f=%b p=%b d=%h",
                 tag, rx_valid, rx_frame_err, rx_parity_err, rx_data, e[9], e[8], e[7:0]);
      end
      rx_ready = 1; @(negedge clk); rx_ready = 0;
    end
    checks++;
    if (rx_valid !== 0 || fifo_count !== 0) begin
      errors++; $display("FAIL %s empty: got v=%b count=%0d expected v=0 count=0", tag, rx_valid, fifo_count);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_data, rx_parity_err, rx_frame_err, rx_valid, fifo_count, overrun, break_det} !== '0) begin
      errors++; $display("FAIL reset outputs: got d=%h v=%b cnt=%0d ovr=%b brk=%b expected all 0",
                         rx_data, rx_valid, fifo_count, overrun, break_det);
    end
  endtask

  task automatic test_basic();
    xfer(8'h55, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (valid_at !== done_idx(8, 0, 0) + 1) begin
      errors++; $display("FAIL basic valid latency: got %0d expected %0d", valid_at, done_idx(8, 0, 0) + 1);
    end
    test_drain("basic");
  endtask

  task automatic test_parity();
    xfer(8'hA3, 1, 0, 0, 1, 1, 1, 0, 0);
    checks++;
    if (rx_parity_err !== 1) begin errors++; $display("FAIL parity even bad: got %b expected 1", rx_parity_err); end
    xfer(8'hA3, 1, 0, 0, 0, 1, 1, 0, 0);
    xfer(8'h3C, 1, 1, 0, 1, 1, 1, 0, 0);
    xfer(8'h3C, 1, 1, 1, 0, 1, 1, 0, 0);
    test_drain("parity");
  endtask

  task automatic test_parity7();
    do_reset();
    send(9'h035, 7, 1, 1, 0, 1, 1, 1, -10, 0, 0);
    send(9'h035, 7, 1, 1, 0, 0, 1, 1, -10, 0, 0);
    checks++;
    if ({d7_count, d7_data, d7_perr, d7_ferr} !== {3'd2, 7'h35, 1'b0, 1'b0}) begin
      errors++; $display("FAIL parity7 first: got cnt=%0d d=%h p=%b f=%b expected cnt=2 d=35 p=0 f=0",
                         d7_count, d7_data, d7_perr, d7_ferr);
    end
    rx_ready = 1; @(negedge clk); rx_ready = 0;
    checks++;
    if ({d7_count, d7_data, d7_perr} !== {3'd1, 7'h35, 1'b1}) begin
      errors++; $display("FAIL parity7 second: got cnt=%0d d=%h p=%b expected cnt=1 d=35 p=1",
                         d7_count, d7_data, d7_perr);
    end
    do_reset();
  endtask

  task automatic test_frame_break();
    xfer(8'h0F, 0, 0, 1, 0, 1, 0, 0, 0);
    checks++;
    if ({rx_frame_err, rx_data, fifo_count} !== {1'b1, 8'h0F, 3'd1}) begin
      errors++; $display("FAIL frame 8N2: got f=%b d=%h cnt=%0d expected f=1 d=0f cnt=1",
                         rx_frame_err, rx_data, fifo_count);
    end
    test_drain("frame");
    pen = 0; odd = 0; two = 0; rx_in = 0;
    repeat (12 * OS) @(negedge clk);
    checks++;
    if ({break_det, fifo_count} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL break held: got brk=%b cnt=%0d expected brk=1 cnt=0", break_det, fifo_count);
    end
    rx_in = 1;
    repeat (2 * OS) @(negedge clk);
    checks++;
    if ({break_det, rx_valid} !== 2'b10) begin
      errors++; $display("FAIL break release: got brk=%b v=%b expected brk=1 v=0", break_det, rx_valid);
    end
    clear_errs = 1; @(negedge clk); clear_errs = 0; @(negedge clk);
    checks++;
    if (break_det !== 0) begin errors++; $display("FAIL break clear: got %b expected 0", break_det); end
    xfer(8'h81, 0, 0, 0, 0, 1, 1, 0, 0);
    test_drain("after break");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) xfer(8'(i), 0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if ({overrun, fifo_count} !== {exp_ovr, 3'd4}) begin
      errors++; $display("FAIL overrun: got ovr=%b cnt=%0d expected ovr=%b cnt=4", overrun, fifo_count, exp_ovr);
    end
    test_drain("overrun");
    clear_errs = 1; @(negedge clk); clear_errs = 0; @(negedge clk);
    exp_ovr = 0;
    checks++;
    if (overrun !== 0) begin errors++; $display("FAIL overrun clear: got %b expected 0", overrun); end
    for (int i = 1; i <= 4; i++) xfer(8'(8'h10 + i), 0, 0, 0, 0, 1, 1, 0, 0);
    xfer(8'h15, 0, 0, 0, 0, 1, 1, 1, 0);
    checks++;
    if (overrun !== exp_ovr) begin errors++; $display("FAIL overrun set-wins: got %b expected %b", overrun, exp_ovr); end
    test_drain("overrun2");
    clear_errs = 1; @(negedge clk); clear_errs = 0; @(negedge clk);
    exp_ovr = 0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) xfer(8'($urandom), 0, 0, 0, 0, 1, 1, 0, 0);
    xfer(8'h77, 0, 0, 0, 0, 1, 1, 0, 1);
    checks++;
    if ({fifo_count, overrun} !== {3'd4, exp_ovr}) begin
      errors++; $display("FAIL full pop: got cnt=%0d ovr=%b expected cnt=4 ovr=%b", fifo_count, overrun, exp_ovr);
    end
    test_drain("full_pop");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      xfer(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0, 0);
      if (i % 3 == 2) test_drain("random");
    end
    checks++;
    if ({overrun, break_det} !== {exp_ovr, exp_brk}) begin
      errors++; $display("FAIL random sticky: got ovr=%b brk=%b expected ovr=%b brk=%b",
                         overrun, break_det, exp_ovr, exp_brk);
    end
    clear_errs = 1; @(negedge clk); clear_errs = 0; @(negedge clk);
    exp_ovr = 0; exp_brk = 0;
  endtask

  task automatic test_glitch_reset();
    rx_in = 0; repeat (4) @(negedge clk); rx_in = 1;
    repeat (3 * OS) @(negedge clk);
    checks++;
    if (rx_valid !== 0) begin errors++; $display("FAIL glitch: got v=%b expected 0", rx_valid); end
    xfer(8'h5A, 0, 0, 0, 0, 1, 1, 0, 0);
    rx_in = 0;
    repeat (3 * OS + 3) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({rx_data, rx_parity_err, rx_frame_err, rx_valid, fifo_count, overrun, break_det} !== '0) begin
      errors++; $display("FAIL reset mid-char: got d=%h v=%b cnt=%0d expected all 0", rx_data, rx_valid, fifo_count);
    end
    rx_in = 1;
    @(negedge clk);
    rst = 0;
    exp_q.delete(); exp_ovr = 0; exp_brk = 0;
    repeat (2 * OS) @(negedge clk);
    xfer(8'hC3, 0, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if ({rx_valid, rx_data} !== {1'b1, 8'hC3}) begin
      errors++; $display("FAIL after reset: got v=%b d=%h expected v=1 d=c3", rx_valid, rx_data);
    end
    test_drain("after reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_parity7();
    test_frame_break();
    test_overrun();
    test_full_pop();
    test_random();
    test_glitch_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_core.md
# uart_rx_fifo_core

Parametrised next-generation UART receiver: oversampled, LSB-first serial input with run-time configurable parity and stop-bit count, compile-time data width and oversample factor, and a show-ahead receive FIFO. Each received character is stored with its own parity and framing error flags. Overrun and break conditions are reported as sticky flags. Sits between the pad-level rx line and the host register/bus interface of the UART peripheral.

## Interface
- DATA_BITS, 8, character width; legal range 5..9
- OVERSAMPLE, 16, clocks per bit; power of 2, at least 8
- FIFO_DEPTH, 4, receive entries; power of 2, at least 2
- SYNC_STAGES, 2, flip-flops in the rx_in synchroniser
- clk  in  1  peripheral clock; the only clock
- rst  in  1  reset; asynchronous, active-high
- rx_in  in  1  raw serial line; idles high
- cfg_parity_en  in  1  a parity bit follows the data bits
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity
- cfg_two_stop  in  1  1 = two stop bits, 0 = one stop bit
- rx_ready  in  1  host pops the head entry when rx_valid is also high
- clear_errs  in  1  clears overrun and break_det
- rx_data  out  DATA_BITS  head entry data
- rx_parity_err  out  1  head entry parity error
- rx_frame_err  out  1  head entry framing error
- rx_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries
- overrun  out  1  sticky: a completed character was dropped
- break_det  out  1  sticky: a break condition was detected

## Operation
- **Synchroniser.** rx_in passes through SYNC_STAGES flip-flops; every statement below refers to the synchronised line. The synchroniser flops reset to 1.
- **Bit timing.**
  - A bit counter runs 0..OVERSAMPLE-1 and is cleared on entry to START.
  - Each bit is sampled once, at counter value OVERSAMPLE/2-1 (the mid-bit point).
- **Configuration latching.** cfg_* inputs are latched on the START→DATA transition. Changes during a character have no effect on that character.
- **FSM states and transitions.**
  - IDLE → START when the line is low.
  - START → IDLE (glitch rejected) if the mid-sample is 1.
  - START → DATA if the mid-sample is 0.
  - DATA collects DATA_BITS samples, LSB first.
  - DATA → PARITY if cfg_parity_en, otherwise DATA → STOP.
  - PARITY samples one bit, then → STOP.
  - STOP samples one stop bit, or two if cfg_two_stop.
  - STOP → IDLE at the mid-sample of the last stop bit, so a start edge arriving half a bit later is caught.
- **Error evaluation.**
  - Parity error: with even parity, the XOR of the data bits and the parity bit is 1; with odd parity, that XOR is 0. Always 0 when parity is disabled.
  - Framing error: any stop-bit sample is 0.
  - Break: all data bits, the parity bit (if enabled) and every stop bit are 0.
- **Break handling.** A break sets break_det and is NOT written to the FIFO. After a break, the FSM returns to IDLE only once the line has been sampled high. This prevents a held-low line from generating repeated characters.
- **Completion and push.**
  - At completion, entry {frame_err, parity_err, data} is pushed if the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the character is dropped, overrun is set, and the stored entries are untouched.
  - A push and pop in the same cycle on a full FIFO: both take effect, count is unchanged, overrun is not set.
  - A push and pop in the same cycle on an empty FIFO cannot occur, because a pop requires rx_valid.
- **FIFO.**
  - Show-ahead: the rx_data and flag outputs always present the head entry.
  - A pop (rx_valid & rx_ready) advances the head in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- **Sticky flags.**
  - overrun and break_det are cleared by clear_errs.
  - If a setting event and clear_errs occur in the same cycle, the set wins.
- **Reset.** All outputs are 0, fifo_count is 0, and the FSM is in IDLE. A reset in the middle of a character discards it. After reset is released, the first falling edge is treated as a new start.

## Timing
- T0 is the first cycle in START. The mid-sample of frame bit k (start bit = 0) is at T0 + k·OVERSAMPLE + OVERSAMPLE/2 - 1.
- The push occurs in the cycle of the last stop bit's mid-sample. rx_valid and fifo_count update the following cycle.
- From the first low rx_in cycle, START is entered after SYNC_STAGES+1 cycles.
- Pop to next head visible: 1 cycle. fifo_count updates 1 cycle after a push or pop.
- A sticky flag becomes visible 1 cycle after its set event or clear_errs.
- Tolerated baud mismatch is about ±(OVERSAMPLE/2-1)/OVERSAMPLE of one bit, accumulated over the whole frame.

## Structure
- Package uart_pkg holds:
  - the enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - the packed struct rx_entry_t {frame_err, parity_err, data}, parametrised via localparam defaults;
  - the helper function parity_calc.
- Sub-module uart_rx_fifo: a generic show-ahead synchronous FIFO with push/pop/full/empty/count. The sampling FSM and bit counter stay in the top module.

## Test plan
- **Basic receive.** 8N1 0x55 at 16 clk/bit → one entry; rx_data=0x55, both error flags 0, rx_valid high exactly 1 cycle after the stop mid-sample.
- **Parity.** 8E1 0xA3 sent with parity bit 1 → parity_err=1. Same character with parity bit 0 → parity_err=0. Repeat with odd parity and DATA_BITS=7.
- **Framing and break.** 8N2 0x0F with second stop bit 0 → frame_err=1, data 0x0F. Line held low for 12 bit times → break_det=1, no FIFO entry, no further entries until the line returns high.
- **Overrun.** 5 characters (0x01..0x05) with rx_ready=0 and FIFO_DEPTH=4 → count=4, overrun=1, pops return 0x01..0x04. With clear_errs pulsed together with the 5th completion, overrun remains 1.
- **Full with simultaneous pop.** FIFO full, pop in the exact completion cycle of character 0x77 → count stays 4, overrun=0, 0x77 is last in order.
- **Glitch and reset.** A 4-cycle low pulse → no entry. rst asserted mid-character → all outputs 0 immediately. A subsequent clean 0xC3 is received correctly.
